// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Responder end of the CPU data-memory port, backed by an internal word
//   array. It accepts a level request, inserts WAIT_CYCLES wait states and
//   completes the transfer with a one-cycle ack. This lets the CPU stall and
//   handshake path be exercised against a multi-cycle memory.
//
// Parameters
//   DEPTH_LOG2  : log2 of the array depth in 32-bit words (default 8 = 1 KiB)
//   WAIT_CYCLES : extra cycles between acceptance and the access cycle (0..15)
//
// Ports
//   clock : system clock, rising edge
//   reset : asynchronous, active-low reset
//   req   : request valid (level, held stable until ack)
//   rw    : 1 = write, 0 = read
//   ain   : byte address
//   din   : write data
//   be    : byte enables; be[i] covers din[8i+7:8i]; ignored on reads
//   dout  : registered read data, held until the next successful read
//   ack   : registered one-cycle completion pulse
//   err   : access fault flag, valid only while ack = 1
//   busy  : high whenever the FSM is not idle
//
// Configuration
//   MEM_RESP_ERR_EN : when defined, misaligned or out-of-range addresses fault
//                     (ack with err = 1, no write, dout unchanged). When
//                     undefined, err is tied low, ain[1:0] is ignored and the
//                     address wraps modulo the array depth.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [31:0] ain,
  input  logic [31:0] din,
  input  logic [3:0]  be,
  output logic [31:0] dout,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        do_access;
  logic        fault;

  // Request fields captured at acceptance; the CPU holds them, but the
  // transaction must not depend on that.
  logic        rw_q;
  logic [31:0] ain_q;
  logic [31:0] din_q;
  logic [3:0]  be_q;

  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           mem [2**DEPTH_LOG2];

  assign idx  = ain_q[DEPTH_LOG2+1:2];
  assign busy = (state_q != S_IDLE);

`ifdef MEM_RESP_ERR_EN
  assign fault = (ain_q[1:0] != 2'b00) || (ain_q[31:DEPTH_LOG2+2] != '0);
`else
  assign fault = 1'b0;
  // Low and high address bits play no part when faults are disabled.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ain_q[1:0], ain_q[31:DEPTH_LOG2+2]};
`endif

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // While ack is high the CPU is still holding the request it just
        // completed; accepting it again would duplicate the transfer.
        if (req && !ack) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        do_access = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack     <= 1'b0;
      dout    <= '0;
      rw_q    <= 1'b0;
      ain_q   <= '0;
      din_q   <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= do_access;
      if (accept) begin
        rw_q  <= rw;
        ain_q <= ain;
        din_q <= din;
        be_q  <= be;
      end
      if (do_access && !rw_q && !fault) dout <= mem[idx];
    end
  end

`ifdef MEM_RESP_ERR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err <= 1'b0;
    else        err <= do_access && fault;
  end
`else
  assign err = 1'b0;
`endif

  // NOTE: the array has no reset; contents survive reset like a real RAM
  // macro. An abandoned transaction cannot write because reset forces the
  // FSM out of S_ACCESS.
  always_ff @(posedge clock) begin
    if (do_access && rw_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= din_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder. A word-array reference model tracks
//   expected memory contents, read data, fault flags and ack latency. Directed
//   scenarios cover reset, timing, byte enables, faults/wrap and reset during
//   a transaction; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  localparam int DEPTH_LOG2  = 8;
  localparam int WAIT_CYCLES = 2;
  localparam int WORDS       = 2 ** DEPTH_LOG2;

  logic        clock;
  logic        reset;
  logic        req;
  logic        rw;
  logic [31:0] ain;
  logic [31:0] din;
  logic [3:0]  be;
  logic [31:0] dout;
  logic        ack;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] model_mem [WORDS];
  logic [31:0] exp_dout;

  mem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req  (req),
    .rw   (rw),
    .ain  (ain),
    .din  (din),
    .be   (be),
    .dout (dout),
    .ack  (ack),
    .err  (err),
    .busy (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
    return (a % 4 != 0) || (a >= 32'(4 * WORDS));
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % WORDS);
  endfunction

  // Runs one transfer starting just after a falling edge and ends just after
  // a falling edge. The request is held through the ack cycle to show that
  // it is not accepted a second time.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    int  n;
    bit  f;
    f   = is_fault(a);
    req = 1'b1; rw = w; ain = a; din = d; be = b;
    n = 0;
    do begin
      @(posedge clock); @(negedge clock);
      n++;
      if (!ack) check("busy_wait", {31'b0, busy}, 32'd1);
    end while (!ack && n < 40);
    check("ack_seen", {31'b0, ack}, 32'd1);
    check("ack_latency", 32'(n), 32'(WAIT_CYCLES + 2));
    check("busy_in_ack", {31'b0, busy}, 32'd0);
    check("err", {31'b0, err}, {31'b0, f});
    if (!f) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) model_mem[word_of(a)][8*i +: 8] = d[8*i +: 8];
      end else begin
        exp_dout = model_mem[word_of(a)];
      end
    end
    check("dout_ack", dout, exp_dout);
    @(posedge clock); @(negedge clock);
    check("ack_drop", {31'b0, ack}, 32'd0);
    check("no_reaccept", {31'b0, busy}, 32'd0);
    check("dout_hold", dout, exp_dout);
    req = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    exp_dout = '0;
    for (int i = 0; i < WORDS; i++) model_mem[i] = '0;

    // Reset held with an active request.
    reset = 1'b0; req = 1'b1; rw = 1'b1; ain = 32'h10; din = 32'h1; be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_ack",  {31'b0, ack},  32'd0);
      check("rst_err",  {31'b0, err},  32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_dout", dout, 32'd0);
    end
    req = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    // Known contents everywhere so every later read is predictable.
    for (int i = 0; i < WORDS; i++) txn(1'b1, 32'(4 * i), $urandom, 4'hF);

    // Basic write and read-back; a later write leaves dout alone.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    txn(1'b0, 32'h10, 32'h0, 4'b0000);
    check("t3_read", dout, 32'hDEADBEEF);
    txn(1'b1, 32'h14, 32'h55555555, 4'b1111);
    check("t3_hold", dout, 32'hDEADBEEF);

    // Byte enables.
    txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    txn(1'b0, 32'h10, 32'h0, 4'b0000);
    check("t4_be", dout, 32'hDEADAAEF);
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    txn(1'b0, 32'h10, 32'h0, 4'b0000);
    check("t4_be0", dout, 32'hDEADAAEF);

    // Misaligned and out-of-range writes.
    txn(1'b1, 32'h11,  32'h11111111, 4'b1111);
    txn(1'b1, 32'h400, 32'h11111111, 4'b1111);
    txn(1'b0, 32'h10, 32'h0, 4'b0000);
`ifdef MEM_RESP_ERR_EN
    check("t5_rd10", dout, 32'hDEADAAEF);
`else
    check("t5_rd10", dout, 32'h11111111);
    txn(1'b0, 32'h00, 32'h0, 4'b0000);
    check("t5_rd00", dout, 32'h11111111);
`endif

    // Reset during the wait phase abandons the write.
    txn(1'b1, 32'h20, 32'h12345678, 4'b1111);
    req = 1'b1; rw = 1'b1; ain = 32'h20; din = 32'hCAFEF00D; be = 4'hF;
    @(posedge clock); @(negedge clock);
    check("t6_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    req   = 1'b0;
    #1;
    check("t6_rst_ack",  {31'b0, ack},  32'd0);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_dout", dout, 32'd0);
    exp_dout = '0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t6_no_ack", {31'b0, ack}, 32'd0);
    end
    txn(1'b0, 32'h20, 32'h0, 4'b0000);
    check("t6_read", dout, 32'h12345678);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 4 * WORDS - 1));
        default: a = 32'($urandom_range(0, WORDS - 1)) * 4;
      endcase
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder (memory) end of the CPU data-memory port, backed by an internal word array.
- Accepts level requests from the CPU load/store unit.
- Inserts a configurable number of wait states, then completes each transfer with a one-cycle ack.
- Lets the CPU's stall/handshake path be exercised against multi-cycle memory before real RAM macros are integrated.

Parameters:
- DEPTH_LOG2, 8, log2 of array depth in 32-bit words (256 words = 1 KiB).
- WAIT_CYCLES, 2, extra cycles between request acceptance and the access cycle; legal range 0..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request valid; level; held with all fields stable until ack.
- rw  input  1  1 = write, 0 = read.
- ain  input  32  byte address.
- din  input  32  write data.
- be  input  4  byte enables; be[i] covers din[8i+7:8i]; ignored on reads.
- dout  output  32  read data, registered.
- ack  output  1  one-cycle completion pulse, registered.
- err  output  1  access fault flag; valid only while ack=1.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, dout=0, ack=0, err=0, busy=0. Array contents are not reset and retain prior values.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: if req=1 and ack=0 at a rising edge, latch rw/ain/din/be. Go to WAIT with counter=WAIT_CYCLES, or to ACCESS if WAIT_CYCLES=0.
  - IDLE: req is ignored while ack=1, so the same held request is never accepted twice.
  - WAIT: counter decrements each edge; leave for ACCESS on the edge where counter=1.
  - ACCESS: at the next edge, perform the access, set ack=1 and err as computed, return to IDLE.
- Latency: request sampled at edge k → ack high for exactly the one cycle following edge k+1+WAIT_CYCLES.
  - Minimum request-to-request spacing: WAIT_CYCLES+3 cycles, including the mandatory ack cycle.
- Write: for each be[i]=1, update that byte of word ain[DEPTH_LOG2+1:2]. be=0000 leaves the array unchanged but still acks.
- Read: dout loads the full word at the ACCESS edge and holds until the next successful read. Writes and faulted accesses never change dout, except as stated under the optional feature.
- ack deasserts on the edge after it rises, unconditionally.
- busy=1 from the edge accepting a request through the ACCESS edge; busy=0 in the ack cycle.
- Fault (macro-dependent, see Optional Feature): a faulted access performs no array write and leaves dout unchanged. It still acks, with err=1.
- Reset mid-operation: the transaction is abandoned; no write, no ack, dout=0. Latched fields are discarded.
- req dropping before ack is a protocol violation; the accepted transaction still completes.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- Defined:
  - Fault = (ain[1:0] != 0) or (ain[31:DEPTH_LOG2+2] != 0).
  - A faulted access sets err=1 with ack, suppresses the write, and leaves dout unchanged.
- Undefined:
  - err tied to 0.
  - ain[1:0] ignored (word-aligned access).
  - Upper address bits ignored, so accesses wrap modulo 2^DEPTH_LOG2 words.

Test Plan:
1. reset=0 for 3 cycles with req=1 → ack=0, err=0, busy=0, dout=0 throughout; no acceptance until reset=1.
2. WAIT_CYCLES=2: write ain=0x10, din=0xDEADBEEF, be=1111, req sampled at edge k → busy high for 3 cycles; ack high only in the cycle after edge k+3; err=0.
3. Read ain=0x10 → dout=0xDEADBEEF in the ack cycle and held after ack drops; a following write to 0x14 leaves dout=0xDEADBEEF.
4. Write ain=0x10, din=0x0000AA00, be=0010, then read 0x10 → dout=0xDEADAAEF. Write with be=0000 → ack=1, value unchanged.
5. Write ain=0x11 (misaligned) and ain=0x400 (out of range, DEPTH_LOG2=8), din=0x11111111:
   - MEM_RESP_ERR_EN defined → ack with err=1, read 0x10 still 0xDEADAAEF.
   - MEM_RESP_ERR_EN undefined → err=0, read 0x10 and 0x00 both return 0x11111111.
6. Preload 0x20=0x12345678; start a write of 0xCAFEF00D to 0x20; pulse reset=0 during WAIT → no ack; after release, read 0x20 → 0x12345678.
